and_gate_core: RTL and testbench

- Parameterized bitwise 2-input AND unit.
- Provides a combinational result z = x & y.
- Also provides a registered, valid-qualified copy of the result, a reduction flag, and a saturating rising-edge counter.
- Leaf primitive for logic datapaths; with WIDTH=1 the combinational path is a plain AND gate.

---
 rtl/and_gate_core.sv | 51 +++++
 tb/tb_and_gate_core.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/and_gate_core.sv
// Bitwise AND unit: combinational z plus a valid-qualified register, AND-reduction flag and saturating rise counter.
// Latency: z is combinational; z_q/out_valid/all_ones/rise_cnt update 1 cycle after in_valid.
// Backpressure: none; in_valid may be asserted every cycle and out_valid pulses once per capture.
module and_gate_core #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] z,
    input  logic             in_valid,
    output logic [WIDTH-1:0] z_q,
    output logic             out_valid,
    output logic             all_ones,
    output logic [CNT_W-1:0] rise_cnt
);

    logic rise;
    logic cnt_sat;

    assign z = x & y;

    // Old z_q[0] is the register contents, so the first capture after reset sees 0.
    assign rise    = in_valid && !z_q[0] && z[0];
    assign cnt_sat = (rise_cnt == {CNT_W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q       <= '0;
            out_valid <= 1'b0;
            all_ones  <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                z_q      <= z;
                all_ones <= &z;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_cnt <= '0;
        end else if (rise && !cnt_sat) begin
            rise_cnt <= rise_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_and_gate_core.sv
// Directed bench for and_gate_core: one WIDTH=1/CNT_W=8 instance and one WIDTH=8/CNT_W=2 instance.
module tb_and_gate_core;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;

    logic       x1, y1, v1;
    logic       z1, zq1, ov1, ao1;
    logic [7:0] cnt1;

    logic [7:0] x2, y2, z2, zq2;
    logic       v2, ov2, ao2;
    logic [1:0] cnt2;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [7:0] zq;
        logic       vld;
        logic       all;
        logic [7:0] cnt;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    logic       m1_zq;
    logic       m1_all;
    logic [7:0] m1_cnt;
    logic [7:0] m2_zq;
    logic       m2_all;
    logic [1:0] m2_cnt;

    always #5 clk = ~clk;

    and_gate_core #(.WIDTH(1), .CNT_W(8)) u1 (
        .clk(clk), .rst_n(rst_n), .x(x1), .y(y1), .z(z1), .in_valid(v1),
        .z_q(zq1), .out_valid(ov1), .all_ones(ao1), .rise_cnt(cnt1)
    );

    and_gate_core #(.WIDTH(8), .CNT_W(2)) u2 (
        .clk(clk), .rst_n(rst_n), .x(x2), .y(y2), .z(z2), .in_valid(v2),
        .z_q(zq2), .out_valid(ov2), .all_ones(ao2), .rise_cnt(cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m1_zq = 1'b0; m1_all = 1'b0; m1_cnt = 8'd0;
        m2_zq = 8'd0; m2_all = 1'b0; m2_cnt = 2'd0;
    endtask

    task automatic step(input logic xa, input logic ya, input logic va,
                        input logic [7:0] xb, input logic [7:0] yb, input logic vb);
        exp_t e1, e2;
        logic       a1;
        logic [7:0] a2;
        exp_t g1, g2;
        @(negedge clk);
        x1 = xa; y1 = ya; v1 = va;
        x2 = xb; y2 = yb; v2 = vb;
        a1 = xa & ya;
        a2 = xb & yb;
        if (va) begin
            if (!m1_zq && a1 && m1_cnt != 8'hFF) m1_cnt = m1_cnt + 8'd1;
            m1_zq  = a1;
            m1_all = a1;
        end
        if (vb) begin
            if (!m2_zq[0] && a2[0] && m2_cnt != 2'd3) m2_cnt = m2_cnt + 2'd1;
            m2_zq  = a2;
            m2_all = (a2 == 8'hFF);
        end
        e1 = '{zq: {7'd0, m1_zq}, vld: va, all: m1_all, cnt: m1_cnt};
        e2 = '{zq: m2_zq, vld: vb, all: m2_all, cnt: {6'd0, m2_cnt}};
        q1.push_back(e1);
        q2.push_back(e2);
        #1;
        chk("z1_comb", {31'd0, z1}, {31'd0, a1});
        chk("z2_comb", {24'd0, z2}, {24'd0, a2});
        @(posedge clk);
        #1;
        g1 = q1.pop_front();
        g2 = q2.pop_front();
        chk("u1_z_q",      {31'd0, zq1}, {24'd0, g1.zq});
        chk("u1_out_valid",{31'd0, ov1}, {31'd0, g1.vld});
        chk("u1_all_ones", {31'd0, ao1}, {31'd0, g1.all});
        chk("u1_rise_cnt", {24'd0, cnt1}, {24'd0, g1.cnt});
        chk("u2_z_q",      {24'd0, zq2}, {24'd0, g2.zq});
        chk("u2_out_valid",{31'd0, ov2}, {31'd0, g2.vld});
        chk("u2_all_ones", {31'd0, ao2}, {31'd0, g2.all});
        chk("u2_rise_cnt", {30'd0, cnt2}, {24'd0, g2.cnt});
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_z_q1"},  {31'd0, zq1},  32'd0);
        chk({tag, "_ov1"},   {31'd0, ov1},  32'd0);
        chk({tag, "_ao1"},   {31'd0, ao1},  32'd0);
        chk({tag, "_cnt1"},  {24'd0, cnt1}, 32'd0);
        chk({tag, "_z_q2"},  {24'd0, zq2},  32'd0);
        chk({tag, "_ov2"},   {31'd0, ov2},  32'd0);
        chk({tag, "_ao2"},   {31'd0, ao2},  32'd0);
        chk({tag, "_cnt2"},  {30'd0, cnt2}, 32'd0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        x1 = 1'b0; y1 = 1'b0; v1 = 1'b0;
        x2 = 8'd0; y2 = 8'd0; v2 = 1'b0;
        model_reset();

        // Reset asserted before any clock edge: outputs clear asynchronously.
        #1 rst_n = 1'b0;
        #1 chk_cleared("reset");

        // Combinational truth table while still in reset.
        x1 = 1'b0; y1 = 1'b0; #1 chk("tt_00", {31'd0, z1}, 32'd0);
        x1 = 1'b1; y1 = 1'b0; #1 chk("tt_10", {31'd0, z1}, 32'd0);
        x1 = 1'b1; y1 = 1'b1; #1 chk("tt_11", {31'd0, z1}, 32'd1);
        y1 = 1'b0;            #1 chk("tt_y0", {31'd0, z1}, 32'd0);

        // in_valid during reset: nothing is captured.
        x1 = 1'b1; y1 = 1'b1; v1 = 1'b1;
        x2 = 8'hFF; y2 = 8'hFF; v2 = 1'b1;
        @(posedge clk); #1;
        chk_cleared("rst_vs_valid");
        v1 = 1'b0; v2 = 1'b0;
        @(negedge clk) rst_n = 1'b1;

        // Single capture, then idle.
        step(1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

        // Mid-cycle asynchronous reset.
        #2 rst_n = 1'b0;
        x1 = 1'b1; y1 = 1'b1;
        #1 chk_cleared("async_rst");
        chk("z_in_reset", {31'd0, z1}, 32'd1);
        model_reset();
        @(negedge clk) rst_n = 1'b1;

        // Edge counting: bit0 sequence 1,1,0,1,0,1 gives 3 rises.
        step(1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
        step(1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
        step(1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
        step(1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
        chk("edge_cnt_3", {24'd0, cnt1}, 32'd3);
        // Non-capture cycle with a would-be rise leaves the count alone.
        step(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
        step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        chk("no_cap_cnt", {24'd0, cnt1}, 32'd3);

        // Wide operand.
        step(1'b0, 1'b0, 1'b0, 8'hF0, 8'h3C, 1'b1);
        chk("wide_z_q", {24'd0, zq2}, 32'h30);
        step(1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1);
        chk("wide_all", {31'd0, ao2}, 32'd1);

        // Saturation at 3 with CNT_W=2: 0/1 alternation gives 4 more rises (5 total).
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
            step(1'b0, 1'b0, 1'b0, 8'h01, 8'h01, 1'b1);
        end
        chk("sat_cnt", {30'd0, cnt2}, 32'd3);
        chk("sat_all", {31'd0, ao2}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
